// File: rtl/pattern_gen.sv
// pattern_gen: plays a small pattern memory out onto WIDTH pins, holding each
// entry for divider+1 clocks. Output launches either from the rising-edge
// register or from a copy retimed onto the falling edge (half a cycle later).
module pattern_gen #(
    parameter  int WIDTH     = 8,
    parameter  int DEPTH     = 16,
    parameter  int DIV_WIDTH = 16,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [AW-1:0]        last_addr,
    input  logic [DIV_WIDTH-1:0] divider,
    input  logic                 loop,
    input  logic                 edge_launch,
    input  logic                 start,
    input  logic                 stop,
    output logic [WIDTH-1:0]     data_out,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]     pos_q, pos_d;
    logic [WIDTH-1:0]     neg_q;
    logic                 done_q, done_d;

    // Shadow copies of the run configuration, captured when a run starts so
    // that host-side changes during playback cannot disturb it.
    logic [AW-1:0]        last_s_q, last_s_d;
    logic [DIV_WIDTH-1:0] div_s_q, div_s_d;
    logic                 loop_s_q, loop_s_d;
    logic                 edge_s_q, edge_s_d;

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [AW-1:0]        addr_inc;
    logic                 edge_sel;

    assign addr_inc = addr_q + AW'(1);

    // Pattern memory write port; locked out while a run is in progress.
    // NOTE: the memory has no reset -- its contents are undefined after reset,
    // and leaving it unreset lets it map onto plain storage without a reset net.
    always_ff @(posedge clock) begin
        if (wr_en && (state_q == IDLE)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Next-state and datapath logic for the IDLE/RUN sequencer.
    // NOTE: every signal is given its hold value first, so no path through the
    // case can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        pos_d    = pos_q;
        done_d   = 1'b0;
        last_s_d = last_s_q;
        div_s_d  = div_s_q;
        loop_s_d = loop_s_q;
        edge_s_d = edge_s_q;

        case (state_q)
            IDLE: begin
                // stop is not looked at here, so start wins when both arrive.
                if (start) begin
                    last_s_d = last_addr;
                    div_s_d  = divider;
                    loop_s_d = loop;
                    edge_s_d = edge_launch;
                    pos_d    = mem_q[0];
                    addr_d   = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    // Abort: value on the pins stays frozen, no done pulse.
                    state_d = IDLE;
                end else if (cnt_q < div_s_q) begin
                    cnt_d = cnt_q + DIV_WIDTH'(1);
                end else begin
                    cnt_d = '0;
                    if (addr_q < last_s_q) begin
                        addr_d = addr_inc;
                        pos_d  = mem_q[addr_inc];
                    end else if (loop_s_q) begin
                        addr_d = '0;
                        pos_d  = mem_q[0];
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Rising-edge state register for the sequencer, launch register and shadows.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            pos_q    <= '0;
            done_q   <= 1'b0;
            last_s_q <= '0;
            div_s_q  <= '0;
            loop_s_q <= 1'b0;
            edge_s_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            pos_q    <= pos_d;
            done_q   <= done_d;
            last_s_q <= last_s_d;
            div_s_q  <= div_s_d;
            loop_s_q <= loop_s_d;
            edge_s_q <= edge_s_d;
        end
    end

    // Falling-edge retiming copy of the launch register.
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            neg_q <= '0;
        end else begin
            neg_q <= pos_q;
        end
    end

    // While idle the live edge_launch picks the source; during a run the shadow does.
    assign edge_sel = (state_q == RUN) ? edge_s_q : edge_launch;
    assign data_out = edge_sel ? pos_q : neg_q;
    assign busy     = (state_q == RUN);
    assign done     = done_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Self-checking bench for pattern_gen: directed scenarios plus randomized runs,
// all compared against a closed-form playback model of the pattern schedule.
module tb_pattern_gen;

    localparam int WIDTH     = 8;
    localparam int DEPTH     = 16;
    localparam int DIV_WIDTH = 16;
    localparam int AW        = 4;

    logic                 clock = 1'b0;
    logic                 reset_n;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [WIDTH-1:0]     wr_data;
    logic [AW-1:0]        last_addr;
    logic [DIV_WIDTH-1:0] divider;
    logic                 loop;
    logic                 edge_launch;
    logic                 start;
    logic                 stop;
    logic [WIDTH-1:0]     data_out;
    logic                 busy;
    logic                 done;

    int checks   = 0;
    int failures = 0;

    // Reference state: memory image, run configuration, value held on the pins.
    logic [WIDTH-1:0] mem_m [DEPTH];
    logic [WIDTH-1:0] held;
    int               cfg_last;
    int               cfg_div;
    bit               cfg_loop;
    bit               cfg_edge;

    pattern_gen #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DIV_WIDTH(DIV_WIDTH)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .last_addr   (last_addr),
        .divider     (divider),
        .loop        (loop),
        .edge_launch (edge_launch),
        .start       (start),
        .stop        (stop),
        .data_out    (data_out),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_mem(input int a, input logic [WIDTH-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a[AW-1:0];
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        mem_m[a] = d;
    endtask

    task automatic load_basic();
        write_mem(0, 8'h11);
        write_mem(1, 8'h22);
        write_mem(2, 8'h33);
        write_mem(3, 8'h44);
    endtask

    // Expected pins/busy/done t edges after the start edge: entry index is
    // t/(div+1), wrapped modulo the pattern length when looping; one-shot ends
    // at t = N*(div+1); a stop at edge stop_at freezes the value from the edge before.
    function automatic void expect_at(input int t, input int stop_at,
                                      output logic [WIDTH-1:0] d,
                                      output logic b, output logic dn);
        int  p;
        int  n;
        int  et;
        bit  stopped;
        p       = cfg_div + 1;
        n       = cfg_last + 1;
        stopped = (stop_at >= 0) && (t >= stop_at);
        et      = stopped ? stop_at - 1 : t;
        b       = 1'b1;
        dn      = 1'b0;
        if (!cfg_loop && et >= n * p) begin
            d  = mem_m[cfg_last];
            b  = 1'b0;
            dn = (t == n * p) && !stopped;
        end else begin
            d = mem_m[(et / p) % n];
        end
        if (stopped) b = 1'b0;
    endfunction

    // Start a run with the current cfg_* and compare for n_cycles edges.
    // poke_at: edge at which a write to mem[1] and a start are attempted mid-run.
    task automatic play(input string name, input int n_cycles, input int stop_at,
                        input int poke_at, input bit with_stop);
        logic [WIDTH-1:0] ed;
        logic [WIDTH-1:0] pd;
        logic             eb;
        logic             edn;
        last_addr   = cfg_last[AW-1:0];
        divider     = cfg_div[DIV_WIDTH-1:0];
        loop        = cfg_loop;
        edge_launch = cfg_edge;
        start       = 1'b1;
        stop        = with_stop;
        pd          = held;
        for (int t = 0; t < n_cycles; t++) begin
            tick();
            start = 1'b0;
            stop  = 1'b0;
            wr_en = 1'b0;
            if (t == 0) begin
                // Disturb the live configuration; the shadows must hold the run.
                last_addr = AW'($urandom);
                divider   = DIV_WIDTH'($urandom_range(0, 7));
                loop      = 1'($urandom);
            end
            expect_at(t, stop_at, ed, eb, edn);
            checks++;
            if (busy !== eb) begin
                failures++;
                $display("FAIL %s busy t=%0d got=%0b exp=%0b", name, t, busy, eb);
            end
            checks++;
            if (done !== edn) begin
                failures++;
                $display("FAIL %s done t=%0d got=%0b exp=%0b", name, t, done, edn);
            end
            if (cfg_edge) begin
                checks++;
                if (data_out !== ed) begin
                    failures++;
                    $display("FAIL %s data t=%0d got=%02h exp=%02h", name, t, data_out, ed);
                end
            end else begin
                checks++;
                if (data_out !== pd) begin
                    failures++;
                    $display("FAIL %s data_pre_neg t=%0d got=%02h exp=%02h", name, t, data_out, pd);
                end
                @(negedge clock);
                #1;
                checks++;
                if (data_out !== ed) begin
                    failures++;
                    $display("FAIL %s data_post_neg t=%0d got=%02h exp=%02h", name, t, data_out, ed);
                end
            end
            pd = ed;
            if (t + 1 == stop_at) stop = 1'b1;
            if (t + 1 == poke_at) begin
                wr_en   = 1'b1;
                wr_addr = AW'(1);
                wr_data = 8'hFF;
                start   = 1'b1;
            end
        end
        held = pd;
        edge_launch = cfg_edge;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        checks++;
        if (data_out !== 8'h00) begin
            failures++;
            $display("FAIL reset data got=%02h exp=00", data_out);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset flags got busy=%0b done=%0b exp=0 0", busy, done);
        end
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        held = '0;
    endtask

    task automatic test_oneshot_basic();
        load_basic();
        cfg_last = 3; cfg_div = 0; cfg_loop = 1'b0; cfg_edge = 1'b1;
        play("oneshot", 7, -1, -1, 1'b0);
    endtask

    task automatic test_loop_stop();
        cfg_last = 3; cfg_div = 2; cfg_loop = 1'b1; cfg_edge = 1'b1;
        play("loop_stop", 20, 15, -1, 1'b0);
    endtask

    task automatic test_falling_edge();
        cfg_last = 3; cfg_div = 0; cfg_loop = 1'b0; cfg_edge = 1'b0;
        play("falling", 7, -1, -1, 1'b0);
    endtask

    task automatic test_busy_writes();
        cfg_last = 3; cfg_div = 3; cfg_loop = 1'b0; cfg_edge = 1'b1;
        play("busy_write", 18, -1, 2, 1'b0);
        // start together with stop in IDLE must launch; mem[1] still 0x22.
        play("start_stop", 18, -1, -1, 1'b1);
    endtask

    task automatic test_single_entry();
        cfg_last = 0; cfg_div = 0; cfg_loop = 1'b0; cfg_edge = 1'b1;
        play("single", 3, -1, -1, 1'b0);
    endtask

    task automatic test_async_reset();
        cfg_last = 3; cfg_div = 1; cfg_loop = 1'b1; cfg_edge = 1'b1;
        last_addr = 2'd3; divider = 1; loop = 1'b1; edge_launch = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b1 || data_out !== 8'h22) begin
            failures++;
            $display("FAIL async_pre got busy=%0b data=%02h exp busy=1 data=22", busy, data_out);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (data_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got data=%02h busy=%0b done=%0b exp 00 0 0",
                     data_out, busy, done);
        end
        tick();
        reset_n = 1'b1;
        held = '0;
        load_basic();
        cfg_last = 3; cfg_div = 0; cfg_loop = 1'b0; cfg_edge = 1'b1;
        play("after_reset", 6, -1, -1, 1'b0);
    endtask

    task automatic test_random();
        int n_cycles;
        int stop_at;
        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < DEPTH; a++) begin
                write_mem(a, WIDTH'($urandom));
            end
            cfg_last = $urandom_range(0, DEPTH - 1);
            cfg_div  = $urandom_range(0, 3);
            cfg_loop = 1'($urandom);
            cfg_edge = 1'($urandom);
            if (cfg_loop) begin
                n_cycles = $urandom_range(5, 40);
                stop_at  = $urandom_range(1, n_cycles - 2);
            end else begin
                n_cycles = (cfg_last + 1) * (cfg_div + 1) + 2;
                stop_at  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n_cycles - 1) : -1;
            end
            play("random", n_cycles, stop_at, -1, 1'b0);
        end
    endtask

    initial begin
        reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        last_addr = '0; divider = '0; loop = 1'b0; edge_launch = 1'b1;
        start = 1'b0; stop = 1'b0; held = '0;
        cfg_last = 0; cfg_div = 0; cfg_loop = 1'b0; cfg_edge = 1'b1;
        for (int a = 0; a < DEPTH; a++) mem_m[a] = '0;
        test_reset();
        test_oneshot_basic();
        test_loop_stop();
        test_falling_edge();
        test_busy_writes();
        test_single_entry();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pattern_gen.md
# pattern_gen

Stimulus pattern generator: the output-side counterpart of the analyzer's edge-selectable input sampler. It plays a small pattern memory out onto WIDTH output pins, holding each entry for a programmable number of clocks. It launches either on the rising edge, or retimed half a cycle later on the falling edge. It sits between the host register interface (memory load, start/stop) and the device-under-test pins.

## Interface
- WIDTH, 8: output pin count / pattern word width.
- DEPTH, 16: pattern memory entries; power of two, ≥2. AW = log2(DEPTH).
- DIV_WIDTH, 16: width of the hold-time divider.
- clock  in  1  system clock; all state on rising edge except the negedge retiming register.
- reset_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  pattern memory write strobe.
- wr_addr  in  AW  write address.
- wr_data  in  WIDTH  write data.
- last_addr  in  AW  index of final entry played (entries 0..last_addr).
- divider  in  DIV_WIDTH  each entry held divider+1 clocks.
- loop  in  1  1 = wrap to entry 0 after last_addr; 0 = one-shot.
- edge_launch  in  1  1 = drive from rising-edge register; 0 = drive from falling-edge retimed copy.
- start  in  1  single-cycle start request.
- stop  in  1  single-cycle abort request.
- data_out  out  WIDTH  pattern to pins.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse on normal one-shot completion.

## Operation
- Storage: DEPTH×WIDTH register array, combinational read. Contents undefined after reset.
- Writes take effect at the rising edge when wr_en=1 and busy=0. Writes while busy=1 are ignored.
- FSM has two states: IDLE and RUN. Reset: IDLE, addr=0, cnt=0, pos_q=0, neg_q=0, busy=0, done=0, so data_out=0.
- IDLE, start=1:
  - Latch last_addr, divider, loop, edge_launch into shadow registers.
  - Load pos_q <= mem[0]; addr=0; cnt=0; go to RUN.
  - stop is ignored in IDLE, so start wins if both are asserted.
- RUN, stop=1: go to IDLE at that edge. No done pulse. pos_q holds its current value. stop has priority over any advance in the same cycle.
- RUN, no stop, cnt < div_s: cnt increments.
- RUN, no stop, cnt == div_s: cnt=0, then one of:
  - addr < last_s: addr+1, pos_q <= mem[addr+1].
  - addr == last_s, loop_s=1: addr=0, pos_q <= mem[0].
  - addr == last_s, loop_s=0: go to IDLE, done=1 for one cycle, pos_q holds the last entry.
- start while in RUN is ignored. Input changes during RUN have no effect, because the shadow registers are used.
- Output stage:
  - neg_q <= pos_q on the falling edge of clock.
  - data_out = edge_s ? pos_q : neg_q, where edge_s is the shadow value, or the live edge_launch input while in IDLE.
- data_out holds its last value in IDLE; it does not return to 0.
- divider=0 means one entry per clock. last_addr=0 means a single-entry pattern.

## Timing
- start sampled at rising edge T0:
  - busy=1 and pos_q=mem[0] after T0.
  - Entry k is visible from edge T0+k·(divider+1) for divider+1 cycles.
- One-shot, N = last_addr+1 entries:
  - At edge T0+N·(divider+1): busy=0 and done=1 for exactly one cycle.
  - data_out keeps mem[last_addr].
  - A new start is accepted on the next edge.
- Loop: at edge T0+N·(divider+1), pos_q=mem[0]. No done pulse, no gap cycle.
- Falling-edge mode: data_out lags the pos_q schedule by half a clock period. Throughput is identical.
- stop sampled at edge Ts: busy=0 after Ts; value frozen.
- Asynchronous reset mid-RUN: immediate IDLE, data_out=0, busy=0, done=0. Memory contents are not guaranteed.

## Test plan
- Load mem[0..3]=0x11,0x22,0x33,0x44; last_addr=3, divider=0, loop=0, edge_launch=1; pulse start.
  - Required: data_out 0x11,0x22,0x33,0x44 on consecutive cycles.
  - Required: done high exactly one cycle at T0+4; busy low from the same edge; data_out stays 0x44.
- Same pattern with divider=2, loop=1.
  - Required: each value held 3 cycles; after 0x44 comes 0x11 with no gap; done never asserts.
  - Then pulse stop: busy=0 the next cycle, value frozen, no done.
- edge_launch=0, divider=0.
  - Required: each data_out transition occurs at the falling edge, half a period after the corresponding pos_q change; values match the rising-edge run.
- Writes while busy:
  - Write mem[1]=0xFF during RUN → ignored; the playback and the next run still output 0x22.
  - start during RUN → ignored; start and stop together in IDLE → run starts.
- last_addr=0, divider=0, one-shot.
  - Required: data_out=mem[0] for one cycle; done at T0+1; busy high exactly one cycle.
- Assert reset_n=0 asynchronously mid-RUN (between edges).
  - Required: data_out=0, busy=0, done=0 immediately.
  - Required: after release, a new start replays from entry 0.
